// File: rtl/xor_share_arb_pkg.sv
// -----------------------------------------------------------------------------
// xor_share_pkg
// Shared definitions for the xor_share_arb block: FSM state encoding and
// requester index constants.
// -----------------------------------------------------------------------------
package xor_share_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    HOLD = ST_HOLD
  } state_t;

endpackage

// File: rtl/xor_share_arb_xor_array.sv
// -----------------------------------------------------------------------------
// xor_array
// Purely combinational N-bit bitwise XOR built from one xor primitive per bit.
// Ports:
//   i_a [N-1:0]  operand A
//   i_b [N-1:0]  operand B
//   o_y [N-1:0]  i_a ^ i_b
// -----------------------------------------------------------------------------
module xor_array #(
  parameter int N = 16
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  output logic [N-1:0] o_y
);

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_bit
      xor u_xor (o_y[gi], i_a[gi], i_b[gi]);
    end
  endgenerate

endmodule

// File: rtl/xor_share_arb.sv
// -----------------------------------------------------------------------------
// xor_share_arb
// Round-robin sequencer sharing one XOR array between two requesters. Each
// operation latches the winner's operands (IDLE), registers the XOR result
// (CALC), then holds it on the output until the consumer takes it (HOLD).
//
// Optional build macro: XOR_SHARE_ARB_PARITY_EN adds out_parity, the reduction
// XOR of out_data, registered alongside it.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req0/a0/b0/ack0     requester 0 request, operands, single-cycle accept
//   req1/a1/b1/ack1     requester 1 request, operands, single-cycle accept
//   out_valid/out_ready result handshake
//   out_data/out_id     registered result and the requester it belongs to
//   out_parity          (macro only) reduction XOR of out_data
//   busy                high whenever the FSM is not IDLE
// -----------------------------------------------------------------------------
module xor_share_arb
  import xor_share_pkg::*;
#(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic [N-1:0] a0,
  input  logic [N-1:0] b0,
  output logic         ack0,
  input  logic         req1,
  input  logic [N-1:0] a1,
  input  logic [N-1:0] b1,
  output logic         ack1,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic         out_id,
`ifdef XOR_SHARE_ARB_PARITY_EN
  output logic         out_parity,
`endif
  output logic         busy
);

  state_t       r_state;
  state_t       w_state_nxt;
  logic         r_rr_ptr;
  logic [N-1:0] r_opa;
  logic [N-1:0] r_opb;
  logic         r_id;
  logic [N-1:0] r_out_data;
  logic         r_out_id;
  logic         r_out_valid;
  logic [N-1:0] w_xor;
  logic         w_gnt_id;
  logic         w_ack0;
  logic         w_ack1;

  // Contention goes to the round-robin pointer; a lone request always wins.
  assign w_gnt_id = (req0 && req1) ? r_rr_ptr : (req1 ? REQ1 : REQ0);

  always_comb begin
    w_state_nxt = r_state;
    w_ack0      = 1'b0;
    w_ack1      = 1'b0;
    unique case (r_state)
      IDLE: begin
        // Reset suppresses the grant so no requester believes it was served.
        if (!rst && (req0 || req1)) begin
          w_ack0      = (w_gnt_id == REQ0);
          w_ack1      = (w_gnt_id == REQ1);
          w_state_nxt = CALC;
        end
      end
      CALC: w_state_nxt = HOLD;
      HOLD: if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  xor_array #(.N(N)) u_xor_array (
    .i_a (r_opa),
    .i_b (r_opb),
    .o_y (w_xor)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr    <= REQ0;
      r_opa       <= '0;
      r_opb       <= '0;
      r_id        <= REQ0;
      r_out_data  <= '0;
      r_out_id    <= REQ0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_ack0 || w_ack1) begin
        r_opa    <= w_gnt_id ? a1 : a0;
        r_opb    <= w_gnt_id ? b1 : b0;
        r_id     <= w_gnt_id;
        r_rr_ptr <= ~w_gnt_id;
      end
      if (r_state == CALC) begin
        r_out_data  <= w_xor;
        r_out_id    <= r_id;
        r_out_valid <= 1'b1;
      end
      if (r_state == HOLD && out_ready) r_out_valid <= 1'b0;
    end
  end

`ifdef XOR_SHARE_ARB_PARITY_EN
  logic r_out_parity;

  always_ff @(posedge clk) begin
    if (rst)                  r_out_parity <= 1'b0;
    else if (r_state == CALC) r_out_parity <= ^w_xor;
  end

  assign out_parity = r_out_parity;
`endif

  assign ack0      = w_ack0;
  assign ack1      = w_ack1;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_id    = r_out_id;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_xor_share_arb.sv
// -----------------------------------------------------------------------------
// tb_xor_share_arb
// Scoreboard bench for xor_share_arb: expected {id,data} entries are queued as
// stimulus is applied and retired whenever a result handshake completes.
// Build with XOR_SHARE_ARB_PARITY_EN defined to also check out_parity.
// -----------------------------------------------------------------------------
module tb_xor_share_arb;

  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1;
  logic [N-1:0] a0, b0, a1, b1;
  logic         ack0, ack1;
  logic         out_valid, out_ready;
  logic [N-1:0] out_data;
  logic         out_id;
  logic         busy;
`ifdef XOR_SHARE_ARB_PARITY_EN
  logic         out_parity;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [N:0] sb[$];   // {id, data}

  always #5 clk = ~clk;

  xor_share_arb #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .a0        (a0),
    .b0        (b0),
    .ack0      (ack0),
    .req1      (req1),
    .a1        (a1),
    .b1        (b1),
    .ack1      (ack1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
`ifdef XOR_SHARE_ARB_PARITY_EN
    .out_parity(out_parity),
`endif
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns at the negedge of the cycle in which the chosen ack is high.
  task automatic wait_ack(input int which);
    bit seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((which == 0) ? ack0 : ack1) begin
        seen = 1;
        break;
      end
    end
    chk("ack_seen", 32'(seen), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      tick();
      if (sb.size() == 0 && !busy) break;
    end
    chk("drain_sb", 32'(sb.size()), 32'd0);
    chk("drain_busy", 32'(busy), 32'd0);
  endtask

  // Scoreboard monitor: a result retires on each edge with valid && ready.
  always @(negedge clk) begin
    if (ack0 === 1'b1 && ack1 === 1'b1) chk("ack_both", 32'd1, 32'd0);
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", {15'd0, out_id, out_data}, 32'hFFFF_FFFF);
      end else begin
        logic [N:0] e;
        e = sb.pop_front();
        chk("sb_data", 32'(out_data), 32'(e[N-1:0]));
        chk("sb_id", 32'(out_id), 32'(e[N]));
`ifdef XOR_SHARE_ARB_PARITY_EN
        chk("sb_parity", 32'(out_parity), 32'(^e[N-1:0]));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; req0 = 1; req1 = 1; out_ready = 1;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;

    // Reset held with both requests active.
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_ack0", 32'(ack0), 32'd0);
    chk("rst_ack1", 32'(ack1), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'h0000);
    chk("rst_busy", 32'(busy), 32'd0);

    // Single request from requester 0.
    tick();
    rst = 0; req1 = 0; req0 = 1; a0 = 16'h0000; b0 = 16'h1111;
    sb.push_back({1'b0, 16'h1111});
    wait_ack(0);
    chk("single_ack1", 32'(ack1), 32'd0);
    tick();
    req0 = 0; a0 = 16'hBAD0;   // late operand change must not matter
    @(negedge clk);
    chk("single_calc_busy", 32'(busy), 32'd1);
    chk("single_calc_valid", 32'(out_valid), 32'd0);
    chk("single_calc_ack0", 32'(ack0), 32'd0);
    tick();
    @(negedge clk);
    chk("single_hold_valid", 32'(out_valid), 32'd1);
    chk("single_hold_data", 32'(out_data), 32'h1111);
    tick();
    @(negedge clk);
    chk("single_idle_busy", 32'(busy), 32'd0);
    chk("single_idle_valid", 32'(out_valid), 32'd0);

    // Contention from a fresh reset: grants alternate starting at 0.
    rst = 1; tick(); tick();
    rst = 0; req0 = 1; req1 = 1;
    a0 = 16'hFFFF; b0 = 16'h0DDD; a1 = 16'hAAAA; b1 = 16'h5555;
    for (int k = 0; k < 6; k++) sb.push_back((k % 2) ? {1'b1, 16'hFFFF} : {1'b0, 16'hF222});
    for (int k = 0; k < 6; k++) begin
      bit seen = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (ack0 || ack1) begin
          seen = 1;
          break;
        end
      end
      chk("cont_seen", 32'(seen), 32'd1);
      chk("cont_gnt", 32'(ack1), 32'(k % 2));
      tick();
    end
    req0 = 0; req1 = 0;
    drain();

    // Backpressure: result held while req1 waits unacknowledged.
    out_ready = 0;
    req0 = 1; a0 = 16'h1234; b0 = 16'h00FF;
    sb.push_back({1'b0, 16'h12CB});
    wait_ack(0);
    tick();
    req0 = 0; req1 = 1; a1 = 16'h0F0F; b1 = 16'hF0F0;
    sb.push_back({1'b1, 16'hFFFF});
    @(negedge clk);
    chk("bp_calc_ack1", 32'(ack1), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data", 32'(out_data), 32'h12CB);
      chk("bp_id", 32'(out_id), 32'd0);
      chk("bp_ack1", 32'(ack1), 32'd0);
    end
    tick();
    out_ready = 1;
    @(negedge clk);
    chk("bp_release_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    chk("bp_idle_ack1", 32'(ack1), 32'd1);
    tick();
    req1 = 0;
    drain();

    // Reset during CALC: the operation vanishes and rr_ptr returns to 0.
    req0 = 1; a0 = 16'hDEAD; b0 = 16'hBEEF;
    wait_ack(0);
    tick();
    req0 = 0; rst = 1;
    @(negedge clk);
    chk("mid_calc_busy", 32'(busy), 32'd1);
    tick();
    rst = 0;
    @(negedge clk);
    chk("mid_valid", 32'(out_valid), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    repeat (4) tick();

    // Parity-oriented operands, also confirming the grant pointer restarted.
    req0 = 1; req1 = 1;
    a0 = 16'h0001; b0 = 16'h0000; a1 = 16'h00FF; b1 = 16'h00FF;
    sb.push_back({1'b0, 16'h0001});
    sb.push_back({1'b1, 16'h0000});
    @(negedge clk);
    chk("post_rst_ack0", 32'(ack0), 32'd1);
    tick();
    req0 = 0;
    wait_ack(1);
    tick();
    req1 = 0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/xor_share_arb.md
Name: xor_share_arb

Overview:
- Shares one N-bit bitwise-XOR datapath between two requesters.
- Round-robin arbitration between requesters.
- Per operation: latches the winner's operand pair, registers the XOR result, then holds it on an output port with a valid/ready handshake and a requester tag.
- Sits between two client blocks and the generate-based XOR array; it is the sole sequencer of that array.

Parameters:
- N, 16, operand/result width in bits (N >= 1).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
- req0  input  1  requester 0 operation request; held high until ack0.
- a0  input  N  requester 0 operand A.
- b0  input  N  requester 0 operand B.
- ack0  output  1  requester 0 operands accepted this cycle.
- req1  input  1  requester 1 operation request; held high until ack1.
- a1  input  N  requester 1 operand A.
- b1  input  N  requester 1 operand B.
- ack1  output  1  requester 1 operands accepted this cycle.
- out_valid  output  1  out_data/out_id valid.
- out_ready  input  1  consumer accepts result.
- out_data  output  N  registered a XOR b of the granted operation.
- out_id  output  1  requester index of out_data.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset values (rst high at an edge): state=IDLE, rr_ptr=0, opA/opB=0, out_data=0, out_id=0, out_valid=0, busy=0.
  - ack0/ack1 are 0 while rst is high.
  - Reset mid-operation discards the operation silently; no result is produced.
- FSM states: IDLE, CALC, HOLD.
- IDLE:
  - No request: stay IDLE.
  - Only one request: grant it.
  - Both requests: grant requester rr_ptr.
  - Grant is combinational: ackG=1 in the same cycle.
  - On that edge: opA/opB <= aG/bG, id <= G, rr_ptr <= ~G, state -> CALC.
- CALC:
  - out_data <= opA ^ opB (via the XOR sub-module), out_id <= id, out_valid <= 1.
  - state -> HOLD unconditionally.
- HOLD:
  - out_valid=1; out_data and out_id stable.
  - If out_ready at an edge: out_valid <= 0, state -> IDLE.
  - Otherwise stay in HOLD indefinitely.
- ack0/ack1:
  - Asserted only in IDLE, never both together.
  - Each is a single-cycle pulse per accepted operation.
  - ack is 0 in CALC and HOLD regardless of req.
- Latency and throughput:
  - Grant edge T -> out_valid high from edge T+2.
  - Minimum cycle time is 3 clocks per op: one each for IDLE, CALC, HOLD with out_ready=1.
- Requester rules:
  - A request dropped before its ack is simply never served.
  - Operands are sampled only on the ack edge; later changes have no effect.
- Fairness: with both requesters continuously requesting, grants strictly alternate 0,1,0,1…, starting at 0 after reset.
- out_ready is ignored outside HOLD.
- busy = (state != IDLE).

Optional Feature:
- Macro: XOR_SHARE_ARB_PARITY_EN.
- Defined:
  - Adds output port out_parity (1 bit) = reduction XOR of out_data.
  - Registered in CALC together with out_data; reset value 0.
- Undefined: port absent; no parity logic.

Decomposition:
- Shared package xor_share_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_CALC=2'd1, ST_HOLD=2'd2.
  - Requester index constants REQ0=1'b0, REQ1=1'b1.
- One sub-module: xor_array (parameter N).
  - Purely combinational bitwise XOR of opA/opB, built with a generate loop of xor primitives.
  - Instantiated once inside xor_share_arb.

Test Plan:
- Reset: assert rst 2 cycles with req0=req1=1 -> ack0=ack1=0, out_valid=0, out_data=16'h0000, busy=0.
- Single request: req0=1, a0=16'h0000, b0=16'h1111, out_ready=1 -> ack0 pulse at T; out_valid at T+2 with out_data=16'h1111, out_id=0; back to IDLE at T+3.
- Contention:
  - Stimulus: req0=req1=1 continuously; a0=16'hFFFF, b0=16'h0DDD, a1=16'hAAAA, b1=16'h5555; out_ready=1.
  - Response: grants alternate 0,1,0,1; results alternate 16'hF222 (id0) and 16'hFFFF (id1).
- Backpressure: out_ready=0 for 5 cycles in HOLD -> out_data/out_id stable, no ack despite req1=1; out_ready=1 -> IDLE, then ack1 next cycle.
- Mid-operation reset: rst pulsed during CALC -> next cycle out_valid=0, state IDLE, rr_ptr=0; the aborted result never appears.
- Parity (XOR_SHARE_ARB_PARITY_EN defined): a0=16'h0001, b0=16'h0000 -> out_parity=1; a0=b0=16'h00FF -> out_data=0, out_parity=0.
